// File: rtl/ddr_dma_arbiter.sv
// ddr_dma_arbiter: shares one DDR DMA write port and one DDR DMA read port
// between two DMA clients (0 = UART DMA, 1 = Ethernet DMA). The write and read
// channels are arbitrated independently. Each channel holds its grant for one
// complete request, from req through req_done. Ties go round-robin.
//
// Per-channel FSM:
//   state  | meaning
//   IDLE   | no owner; sample client reqs and grant one
//   REQ    | m_req held high toward the DDR wrapper until m_ack
//   XFER   | data path routed to the granted client until m_req_done
module ddr_dma_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 32,
    parameter int DATA_W = 32
) (
    input  logic              dma_clk,
    input  logic              dma_rstn,

    // client 0 write
    input  logic              c0_wr_req,
    input  logic [ADDR_W-1:0] c0_wr_addr,
    input  logic [LEN_W-1:0]  c0_wr_len,
    input  logic [DATA_W-1:0] c0_wr_data,
    input  logic              c0_wr_data_ready,
    output logic              c0_wr_ack,
    output logic              c0_wr_data_req,
    output logic              c0_wr_req_done,
    // client 1 write
    input  logic              c1_wr_req,
    input  logic [ADDR_W-1:0] c1_wr_addr,
    input  logic [LEN_W-1:0]  c1_wr_len,
    input  logic [DATA_W-1:0] c1_wr_data,
    input  logic              c1_wr_data_ready,
    output logic              c1_wr_ack,
    output logic              c1_wr_data_req,
    output logic              c1_wr_req_done,
    // client 0 read
    input  logic              c0_rd_req,
    input  logic [ADDR_W-1:0] c0_rd_addr,
    input  logic [LEN_W-1:0]  c0_rd_len,
    input  logic              c0_rd_data_ready,
    output logic [DATA_W-1:0] c0_rd_data,
    output logic              c0_rd_ack,
    output logic              c0_rd_data_valid,
    output logic              c0_rd_req_done,
    // client 1 read
    input  logic              c1_rd_req,
    input  logic [ADDR_W-1:0] c1_rd_addr,
    input  logic [LEN_W-1:0]  c1_rd_len,
    input  logic              c1_rd_data_ready,
    output logic [DATA_W-1:0] c1_rd_data,
    output logic              c1_rd_ack,
    output logic              c1_rd_data_valid,
    output logic              c1_rd_req_done,

    // master write port
    output logic              m_wr_req,
    output logic [ADDR_W-1:0] m_wr_addr,
    output logic [LEN_W-1:0]  m_wr_len,
    output logic [DATA_W-1:0] m_wr_data,
    output logic              m_wr_data_ready,
    input  logic              m_wr_ack,
    input  logic              m_wr_data_req,
    input  logic              m_wr_req_done,
    // master read port
    output logic              m_rd_req,
    output logic [ADDR_W-1:0] m_rd_addr,
    output logic [LEN_W-1:0]  m_rd_len,
    output logic              m_rd_data_ready,
    input  logic              m_rd_ack,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              m_rd_data_valid,
    input  logic              m_rd_req_done,

    output logic              wr_busy,
    output logic              rd_busy,
    output logic              wr_gnt,
    output logic              rd_gnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER
    } state_t;

    state_t wr_state;
    state_t rd_state;
    logic   wr_last;
    logic   rd_last;
    logic   wr_win;
    logic   rd_win;
    logic   wr_in_req;
    logic   wr_in_xfer;
    logic   rd_in_req;
    logic   rd_in_xfer;

    // On a tie the client that did not own the previous transfer wins
    assign wr_win = (c0_wr_req & c1_wr_req) ? ~wr_last : c1_wr_req;
    assign rd_win = (c0_rd_req & c1_rd_req) ? ~rd_last : c1_rd_req;

    // Write channel FSM: grant, hold m_req until ack, own the port until done
    always_ff @(posedge dma_clk or negedge dma_rstn) begin
        if (!dma_rstn) begin
            wr_state  <= S_IDLE;
            wr_gnt    <= 1'b0;
            wr_last   <= 1'b1;
            m_wr_req  <= 1'b0;
            m_wr_addr <= '0;
            m_wr_len  <= '0;
        end else begin
            case (wr_state)
                S_IDLE: begin
                    if (c0_wr_req | c1_wr_req) begin
                        wr_gnt    <= wr_win;
                        m_wr_addr <= wr_win ? c1_wr_addr : c0_wr_addr;
                        m_wr_len  <= wr_win ? c1_wr_len  : c0_wr_len;
                        m_wr_req  <= 1'b1;
                        wr_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    // a done arriving with the ack is only honoured in XFER
                    if (m_wr_ack) begin
                        m_wr_req <= 1'b0;
                        wr_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (m_wr_req_done) begin
                        wr_last  <= wr_gnt;
                        wr_state <= S_IDLE;
                    end
                end
                default: wr_state <= S_IDLE;
            endcase
        end
    end

    // Read channel FSM: same sequencing as the write channel
    always_ff @(posedge dma_clk or negedge dma_rstn) begin
        if (!dma_rstn) begin
            rd_state  <= S_IDLE;
            rd_gnt    <= 1'b0;
            rd_last   <= 1'b1;
            m_rd_req  <= 1'b0;
            m_rd_addr <= '0;
            m_rd_len  <= '0;
        end else begin
            case (rd_state)
                S_IDLE: begin
                    if (c0_rd_req | c1_rd_req) begin
                        rd_gnt    <= rd_win;
                        m_rd_addr <= rd_win ? c1_rd_addr : c0_rd_addr;
                        m_rd_len  <= rd_win ? c1_rd_len  : c0_rd_len;
                        m_rd_req  <= 1'b1;
                        rd_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (m_rd_ack) begin
                        m_rd_req <= 1'b0;
                        rd_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (m_rd_req_done) begin
                        rd_last  <= rd_gnt;
                        rd_state <= S_IDLE;
                    end
                end
                default: rd_state <= S_IDLE;
            endcase
        end
    end

    assign wr_in_req  = (wr_state == S_REQ);
    assign wr_in_xfer = (wr_state == S_XFER);
    assign rd_in_req  = (rd_state == S_REQ);
    assign rd_in_xfer = (rd_state == S_XFER);

    assign wr_busy = (wr_state != S_IDLE);
    assign rd_busy = (rd_state != S_IDLE);

    // Master responses are routed only to the owner and only in the phase
    // where they mean something; strays in IDLE go nowhere.
    assign c0_wr_ack      = wr_in_req  & ~wr_gnt & m_wr_ack;
    assign c1_wr_ack      = wr_in_req  &  wr_gnt & m_wr_ack;
    assign c0_wr_data_req = wr_in_xfer & ~wr_gnt & m_wr_data_req;
    assign c1_wr_data_req = wr_in_xfer &  wr_gnt & m_wr_data_req;
    assign c0_wr_req_done = wr_in_xfer & ~wr_gnt & m_wr_req_done;
    assign c1_wr_req_done = wr_in_xfer &  wr_gnt & m_wr_req_done;

    assign m_wr_data       = wr_gnt ? c1_wr_data : c0_wr_data;
    assign m_wr_data_ready = wr_in_xfer & (wr_gnt ? c1_wr_data_ready : c0_wr_data_ready);

    assign c0_rd_ack        = rd_in_req  & ~rd_gnt & m_rd_ack;
    assign c1_rd_ack        = rd_in_req  &  rd_gnt & m_rd_ack;
    assign c0_rd_data_valid = rd_in_xfer & ~rd_gnt & m_rd_data_valid;
    assign c1_rd_data_valid = rd_in_xfer &  rd_gnt & m_rd_data_valid;
    assign c0_rd_req_done   = rd_in_xfer & ~rd_gnt & m_rd_req_done;
    assign c1_rd_req_done   = rd_in_xfer &  rd_gnt & m_rd_req_done;

    // Read data is broadcast; data_valid tells the owner when to take it
    assign c0_rd_data = m_rd_data;
    assign c1_rd_data = m_rd_data;

    assign m_rd_data_ready = rd_in_xfer & (rd_gnt ? c1_rd_data_ready : c0_rd_data_ready);

endmodule

// File: tb/tb_ddr_dma_arbiter.sv
// Bench for ddr_dma_arbiter: arbitration table on the write channel, hand
// sequences for transfer corner cases, then random traffic on both channels
// against a transaction-level model of each channel's owner.
module tb_ddr_dma_arbiter;

    logic        dma_clk = 1'b0;
    logic        dma_rstn;

    logic        c0_wr_req, c1_wr_req, c0_rd_req, c1_rd_req;
    logic [31:0] c0_wr_addr, c1_wr_addr, c0_rd_addr, c1_rd_addr;
    logic [31:0] c0_wr_len, c1_wr_len, c0_rd_len, c1_rd_len;
    logic [31:0] c0_wr_data, c1_wr_data;
    logic        c0_wr_data_ready, c1_wr_data_ready, c0_rd_data_ready, c1_rd_data_ready;
    logic        c0_wr_ack, c1_wr_ack, c0_wr_data_req, c1_wr_data_req;
    logic        c0_wr_req_done, c1_wr_req_done;
    logic [31:0] c0_rd_data, c1_rd_data;
    logic        c0_rd_ack, c1_rd_ack, c0_rd_data_valid, c1_rd_data_valid;
    logic        c0_rd_req_done, c1_rd_req_done;
    logic        m_wr_req, m_wr_data_ready, m_wr_ack, m_wr_data_req, m_wr_req_done;
    logic [31:0] m_wr_addr, m_wr_len, m_wr_data;
    logic        m_rd_req, m_rd_data_ready, m_rd_ack, m_rd_data_valid, m_rd_req_done;
    logic [31:0] m_rd_addr, m_rd_len, m_rd_data;
    logic        wr_busy, rd_busy, wr_gnt, rd_gnt;

    always #5 dma_clk = ~dma_clk;

    ddr_dma_arbiter #(.ADDR_W(32), .LEN_W(32), .DATA_W(32)) dut (
        .dma_clk(dma_clk), .dma_rstn(dma_rstn),
        .c0_wr_req(c0_wr_req), .c0_wr_addr(c0_wr_addr), .c0_wr_len(c0_wr_len),
        .c0_wr_data(c0_wr_data), .c0_wr_data_ready(c0_wr_data_ready),
        .c0_wr_ack(c0_wr_ack), .c0_wr_data_req(c0_wr_data_req), .c0_wr_req_done(c0_wr_req_done),
        .c1_wr_req(c1_wr_req), .c1_wr_addr(c1_wr_addr), .c1_wr_len(c1_wr_len),
        .c1_wr_data(c1_wr_data), .c1_wr_data_ready(c1_wr_data_ready),
        .c1_wr_ack(c1_wr_ack), .c1_wr_data_req(c1_wr_data_req), .c1_wr_req_done(c1_wr_req_done),
        .c0_rd_req(c0_rd_req), .c0_rd_addr(c0_rd_addr), .c0_rd_len(c0_rd_len),
        .c0_rd_data_ready(c0_rd_data_ready), .c0_rd_data(c0_rd_data), .c0_rd_ack(c0_rd_ack),
        .c0_rd_data_valid(c0_rd_data_valid), .c0_rd_req_done(c0_rd_req_done),
        .c1_rd_req(c1_rd_req), .c1_rd_addr(c1_rd_addr), .c1_rd_len(c1_rd_len),
        .c1_rd_data_ready(c1_rd_data_ready), .c1_rd_data(c1_rd_data), .c1_rd_ack(c1_rd_ack),
        .c1_rd_data_valid(c1_rd_data_valid), .c1_rd_req_done(c1_rd_req_done),
        .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_len(m_wr_len),
        .m_wr_data(m_wr_data), .m_wr_data_ready(m_wr_data_ready),
        .m_wr_ack(m_wr_ack), .m_wr_data_req(m_wr_data_req), .m_wr_req_done(m_wr_req_done),
        .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_len(m_rd_len),
        .m_rd_data_ready(m_rd_data_ready), .m_rd_ack(m_rd_ack), .m_rd_data(m_rd_data),
        .m_rd_data_valid(m_rd_data_valid), .m_rd_req_done(m_rd_req_done),
        .wr_busy(wr_busy), .rd_busy(rd_busy), .wr_gnt(wr_gnt), .rd_gnt(rd_gnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // client-side event counters for the single-write sequence
    int c0_ack_cnt = 0;
    int c0_done_cnt = 0;
    int c1_act_cnt = 0;
    always @(posedge dma_clk) begin
        if (c0_wr_ack)      c0_ack_cnt  <= c0_ack_cnt + 1;
        if (c0_wr_req_done) c0_done_cnt <= c0_done_cnt + 1;
        if (c1_wr_ack | c1_wr_data_req | c1_wr_req_done) c1_act_cnt <= c1_act_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic clr_in();
        c0_wr_req = 0; c1_wr_req = 0; c0_rd_req = 0; c1_rd_req = 0;
        c0_wr_addr = 0; c1_wr_addr = 0; c0_rd_addr = 0; c1_rd_addr = 0;
        c0_wr_len = 0; c1_wr_len = 0; c0_rd_len = 0; c1_rd_len = 0;
        c0_wr_data = 0; c1_wr_data = 0;
        c0_wr_data_ready = 0; c1_wr_data_ready = 0; c0_rd_data_ready = 0; c1_rd_data_ready = 0;
        m_wr_ack = 0; m_wr_data_req = 0; m_wr_req_done = 0;
        m_rd_ack = 0; m_rd_data = 0; m_rd_data_valid = 0; m_rd_req_done = 0;
    endtask

    task automatic do_reset();
        dma_rstn = 0;
        clr_in();
        repeat (2) @(negedge dma_clk);
        dma_rstn = 1;
    endtask

    // arbitration table, write channel; exp = {m_req,gnt,busy,a0,a1,dq0,dq1,d0,d1}
    typedef struct {
        logic       r0;
        logic       r1;
        logic       ack;
        logic       done;
        logic       dq;
        logic [8:0] exp;
    } vec_t;
    vec_t tv[16];
    localparam int N_TV = 14;

    // random stimulus and the per-channel model (index 0 = write, 1 = read)
    logic        rq[2][2];
    logic [31:0] ra[2][2];
    logic [31:0] rl[2][2];
    logic        rdy[2][2];
    logic        mack[2], mdone[2], mdq[2];
    logic [31:0] wd[2];
    logic [31:0] rdd;

    logic        mo_busy[2], mo_own[2], mo_acked[2], mo_last[2], mo_gnt[2];
    logic [31:0] mo_addr[2], mo_len[2];

    task automatic model_reset();
        mo_busy[0] = 0; mo_own[0] = 0; mo_acked[0] = 0; mo_last[0] = 1; mo_gnt[0] = 0;
        mo_busy[1] = 0; mo_own[1] = 0; mo_acked[1] = 0; mo_last[1] = 1; mo_gnt[1] = 0;
        mo_addr[0] = 0; mo_len[0] = 0; mo_addr[1] = 0; mo_len[1] = 0;
    endtask

    // one clock of a channel: start a transaction, note its ack, or retire it
    task automatic model_step(input logic ch);
        logic w;
        if (!mo_busy[ch]) begin
            if (rq[ch][0] || rq[ch][1]) begin
                if (rq[ch][0] && rq[ch][1]) w = !mo_last[ch];
                else if (rq[ch][0])         w = 1'b0;
                else                        w = 1'b1;
                mo_busy[ch]  = 1;
                mo_own[ch]   = w;
                mo_gnt[ch]   = w;
                mo_acked[ch] = 0;
                mo_addr[ch]  = ra[ch][w];
                mo_len[ch]   = rl[ch][w];
            end
        end else if (!mo_acked[ch]) begin
            if (mack[ch]) mo_acked[ch] = 1;
        end else if (mdone[ch]) begin
            mo_last[ch] = mo_own[ch];
            mo_busy[ch] = 0;
        end
    endtask

    // {m_req,busy,gnt,a0,a1,dq0,dq1,d0,d1,m_data_ready}
    function automatic logic [9:0] model_ctl(input logic ch);
        logic waiting, moving, o;
        waiting = mo_busy[ch] && !mo_acked[ch];
        moving  = mo_busy[ch] && mo_acked[ch];
        o       = mo_own[ch];
        return {waiting, mo_busy[ch], mo_gnt[ch],
                waiting && !o && mack[ch], waiting && o && mack[ch],
                moving && !o && mdq[ch],   moving && o && mdq[ch],
                moving && !o && mdone[ch], moving && o && mdone[ch],
                moving && rdy[ch][o]};
    endfunction

    task automatic rnd_ch(input logic ch);
        rq[ch][0]  = ($urandom_range(0, 3) != 0);
        rq[ch][1]  = ($urandom_range(0, 3) != 0);
        ra[ch][0]  = $urandom();
        ra[ch][1]  = $urandom();
        rl[ch][0]  = $urandom();
        rl[ch][1]  = $urandom();
        rdy[ch][0] = ($urandom_range(0, 1) == 1);
        rdy[ch][1] = ($urandom_range(0, 1) == 1);
        mack[ch]   = ($urandom_range(0, 2) == 0);
        mdone[ch]  = ($urandom_range(0, 3) == 0);
        mdq[ch]    = ($urandom_range(0, 1) == 1);
    endtask

    logic [31:0] ew;

    initial begin
        tv[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b000_00_00_00};
        tv[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'b101_10_00_00};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'b001_00_10_00};
        tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'b001_00_00_10};
        tv[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b000_00_00_00};
        tv[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'b111_01_00_00};
        tv[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'b011_00_00_01};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b010_00_00_00};
        tv[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'b101_10_00_00};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b001_00_10_10};
        tv[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b000_00_00_00};
        tv[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'b000_00_00_00};
        tv[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b000_00_00_00};
        tv[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b111_00_00_00};
        tv[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000_00_00_00};
        tv[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000_00_00_00};

        // ---- reset state with every master response and ready driven high
        dma_rstn = 1;
        clr_in();
        #1 dma_rstn = 0;
        m_wr_ack = 1; m_wr_data_req = 1; m_wr_req_done = 1;
        m_rd_ack = 1; m_rd_data_valid = 1; m_rd_req_done = 1; m_rd_data = 32'h1234;
        c0_wr_data_ready = 1; c1_wr_data_ready = 1; c0_rd_data_ready = 1; c1_rd_data_ready = 1;
        c0_wr_req = 1; c1_rd_req = 1; c0_wr_data = 32'hBEEF;
        #3;
        chk("rst_ctl", 64'({m_wr_req, m_rd_req, wr_busy, rd_busy, wr_gnt, rd_gnt}), 64'd0);
        chk("rst_wr_desc", 64'({m_wr_addr, m_wr_len}), 64'd0);
        chk("rst_rd_desc", 64'({m_rd_addr, m_rd_len}), 64'd0);
        chk("rst_gated", 64'({c0_wr_ack, c1_wr_ack, c0_wr_data_req, c1_wr_data_req,
                              c0_wr_req_done, c1_wr_req_done, c0_rd_ack, c1_rd_ack,
                              c0_rd_data_valid, c1_rd_data_valid, c0_rd_req_done,
                              c1_rd_req_done, m_wr_data_ready, m_rd_data_ready}), 64'd0);
        chk("rst_rd_pass", 64'({c0_rd_data, c1_rd_data}), 64'h0000_1234_0000_1234);
        chk("rst_wr_pass", 64'(m_wr_data), 64'hBEEF);
        do_reset();

        // ---- arbitration table: tie after reset, alternation, strays in IDLE
        for (int i = 0; i < N_TV; i++) begin
            c0_wr_req     = tv[i[3:0]].r0;
            c1_wr_req     = tv[i[3:0]].r1;
            m_wr_ack      = tv[i[3:0]].ack;
            m_wr_req_done = tv[i[3:0]].done;
            m_wr_data_req = tv[i[3:0]].dq;
            #1;
            chk($sformatf("tab%0d", i),
                64'({m_wr_req, wr_gnt, wr_busy, c0_wr_ack, c1_wr_ack, c0_wr_data_req,
                     c1_wr_data_req, c0_wr_req_done, c1_wr_req_done}),
                64'(tv[i[3:0]].exp));
            @(negedge dma_clk);
        end
        do_reset();

        // ---- single write from client 0, 16 beats
        begin
            int b_ack, b_done, b_c1;
            b_ack = c0_ack_cnt; b_done = c0_done_cnt; b_c1 = c1_act_cnt;
            c0_wr_addr = 32'h1000; c0_wr_len = 32'd64; c0_wr_req = 1;
            c1_wr_addr = 32'hDEAD; c1_wr_len = 32'd7;
            #1 chk("sw_not_yet", 64'(m_wr_req), 64'd0);
            @(negedge dma_clk); #1;
            chk("sw_grant", 64'({m_wr_req, wr_gnt}), 64'b10);
            chk("sw_desc", 64'({m_wr_addr, m_wr_len}), {32'h1000, 32'd64});
            repeat (2) @(negedge dma_clk);
            m_wr_ack = 1;
            #1 chk("sw_ack", 64'({c0_wr_ack, c1_wr_ack, m_wr_req}), 64'b101);
            @(negedge dma_clk);
            m_wr_ack = 0; c0_wr_req = 0;
            #1 chk("sw_req_drop", 64'({m_wr_req, wr_busy}), 64'b01);
            for (int i = 0; i < 16; i++) begin
                ew = 32'hA000 + i;
                c0_wr_data = ew; c0_wr_data_ready = 1; m_wr_data_req = 1;
                c1_wr_data = 32'h5555_0000 + i;
                #1;
                chk($sformatf("sw_beat%0d", i),
                    64'({m_wr_data, m_wr_data_ready, c0_wr_data_req, c1_wr_data_req}),
                    64'({ew, 3'b110}));
                @(negedge dma_clk);
            end
            m_wr_data_req = 0; c0_wr_data_ready = 0; m_wr_req_done = 1;
            #1 chk("sw_done", 64'({c0_wr_req_done, c1_wr_req_done}), 64'b10);
            @(negedge dma_clk);
            m_wr_req_done = 0;
            #1 chk("sw_idle", 64'(wr_busy), 64'd0);
            chk("sw_c0_acks", 64'(c0_ack_cnt - b_ack), 64'd1);
            chk("sw_c0_dones", 64'(c0_done_cnt - b_done), 64'd1);
            chk("sw_c1_quiet", 64'(c1_act_cnt - b_c1), 64'd0);
        end

        // ---- concurrent c0 write / c1 read, descriptor change during REQ
        clr_in();
        c0_wr_req = 1; c0_wr_addr = 32'h4000; c0_wr_len = 32'd16;
        c1_rd_req = 1; c1_rd_addr = 32'h200;  c1_rd_len = 32'd8;
        c0_rd_addr = 32'h999;
        @(negedge dma_clk); #1;
        chk("cc_mreq", 64'({m_wr_req, m_rd_req, wr_gnt, rd_gnt}), 64'b1101);
        chk("cc_rd_desc", 64'({m_rd_addr, m_rd_len}), {32'h200, 32'd8});
        c1_rd_addr = 32'h300; c1_rd_len = 32'd99;
        @(negedge dma_clk); #1;
        chk("dc_hold_req", 64'({m_rd_addr, m_rd_len}), {32'h200, 32'd8});
        m_wr_ack = 1; m_rd_ack = 1;
        #1 chk("cc_ack", 64'({c0_wr_ack, c1_wr_ack, c0_rd_ack, c1_rd_ack}), 64'b1001);
        @(negedge dma_clk);
        m_wr_ack = 0; m_rd_ack = 0; c0_wr_req = 0; c1_rd_req = 0;
        m_rd_data = 32'h55AA; m_rd_data_valid = 1; c1_rd_data_ready = 1; m_wr_data_req = 1;
        #1;
        chk("cc_rd_valid", 64'({c0_rd_data_valid, c1_rd_data_valid, m_rd_data_ready}), 64'b011);
        chk("cc_wr_dreq", 64'({c0_wr_data_req, c1_wr_data_req}), 64'b10);
        chk("cc_rd_data", 64'(c1_rd_data), 64'h55AA);
        chk("dc_hold_xfer", 64'(m_rd_addr), 64'h200);
        @(negedge dma_clk);
        c1_rd_data_ready = 0; c0_rd_data_ready = 1;
        #1 chk("cc_rd_ready_gate", 64'(m_rd_data_ready), 64'd0);
        @(negedge dma_clk);
        m_rd_data_valid = 0; m_wr_data_req = 0; m_wr_req_done = 1; m_rd_req_done = 1;
        #1 chk("cc_done", 64'({c0_wr_req_done, c1_wr_req_done, c0_rd_req_done, c1_rd_req_done}),
               64'b1001);
        @(negedge dma_clk);
        clr_in();
        #1 chk("cc_idle", 64'({wr_busy, rd_busy}), 64'd0);
        @(negedge dma_clk);

        // ---- reset during write beat 5 of 16
        c0_wr_req = 1; c0_wr_addr = 32'h8000; c0_wr_len = 32'd64;
        @(negedge dma_clk);
        m_wr_ack = 1;
        @(negedge dma_clk);
        m_wr_ack = 0; c0_wr_req = 0;
        for (int i = 0; i < 4; i++) begin
            c0_wr_data = 32'hB000 + i; c0_wr_data_ready = 1; m_wr_data_req = 1;
            @(negedge dma_clk);
        end
        c0_wr_data = 32'hB004;
        #2 dma_rstn = 0;
        m_wr_req_done = 1;
        #1;
        chk("mr_ctl", 64'({wr_busy, m_wr_req, wr_gnt, m_wr_data_ready, c0_wr_data_req,
                           c0_wr_req_done}), 64'd0);
        chk("mr_desc", 64'({m_wr_addr, m_wr_len}), 64'd0);
        @(negedge dma_clk);
        clr_in();
        dma_rstn = 1;
        c1_wr_req = 1; c1_wr_addr = 32'h7000; c1_wr_len = 32'd4;
        @(negedge dma_clk); #1;
        chk("mr_regrant", 64'({m_wr_req, wr_gnt}), 64'b11);
        chk("mr_regrant_addr", 64'(m_wr_addr), 64'h7000);
        m_wr_ack = 1;
        @(negedge dma_clk);
        m_wr_ack = 0; c1_wr_req = 0; m_wr_req_done = 1;
        #1 chk("mr_c1_done", 64'({c0_wr_req_done, c1_wr_req_done}), 64'b01);
        @(negedge dma_clk);
        m_wr_req_done = 0; c0_wr_req = 1; c1_wr_req = 1;
        @(negedge dma_clk); #1;
        chk("mr_tie_after_c1", 64'({m_wr_req, wr_gnt}), 64'b10);
        do_reset();

        // ---- random traffic on both channels against the model
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rnd_ch(1'b0);
            rnd_ch(1'b1);
            wd[0] = $urandom(); wd[1] = $urandom(); rdd = $urandom();
            c0_wr_req = rq[0][0]; c1_wr_req = rq[0][1];
            c0_wr_addr = ra[0][0]; c1_wr_addr = ra[0][1];
            c0_wr_len = rl[0][0]; c1_wr_len = rl[0][1];
            c0_wr_data_ready = rdy[0][0]; c1_wr_data_ready = rdy[0][1];
            c0_wr_data = wd[0]; c1_wr_data = wd[1];
            m_wr_ack = mack[0]; m_wr_req_done = mdone[0]; m_wr_data_req = mdq[0];
            c0_rd_req = rq[1][0]; c1_rd_req = rq[1][1];
            c0_rd_addr = ra[1][0]; c1_rd_addr = ra[1][1];
            c0_rd_len = rl[1][0]; c1_rd_len = rl[1][1];
            c0_rd_data_ready = rdy[1][0]; c1_rd_data_ready = rdy[1][1];
            m_rd_ack = mack[1]; m_rd_req_done = mdone[1]; m_rd_data_valid = mdq[1];
            m_rd_data = rdd;
            #1;
            chk("rnd_wr_ctl",
                64'({m_wr_req, wr_busy, wr_gnt, c0_wr_ack, c1_wr_ack, c0_wr_data_req,
                     c1_wr_data_req, c0_wr_req_done, c1_wr_req_done, m_wr_data_ready}),
                64'(model_ctl(1'b0)));
            chk("rnd_rd_ctl",
                64'({m_rd_req, rd_busy, rd_gnt, c0_rd_ack, c1_rd_ack, c0_rd_data_valid,
                     c1_rd_data_valid, c0_rd_req_done, c1_rd_req_done, m_rd_data_ready}),
                64'(model_ctl(1'b1)));
            chk("rnd_wr_desc", 64'({m_wr_addr, m_wr_len}), {mo_addr[0], mo_len[0]});
            chk("rnd_rd_desc", 64'({m_rd_addr, m_rd_len}), {mo_addr[1], mo_len[1]});
            chk("rnd_wr_data", 64'(m_wr_data), 64'(wd[mo_gnt[0]]));
            chk("rnd_rd_data", 64'({c0_rd_data, c1_rd_data}), {rdd, rdd});
            @(posedge dma_clk);
            model_step(1'b0);
            model_step(1'b1);
            @(negedge dma_clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
